// File: rtl/puf_vote_engine_pkg.sv
// Shared definitions for the arbiter-PUF majority-vote engine: controller
// state encoding, default sizing constants and the vote-counter width helper.
package puf_pkg;

    localparam int DEF_N      = 128;
    localparam int DEF_VOTES  = 5;
    localparam int DEF_SETTLE = 4;

    // Bits needed to count from 0 up to and including 'votes'.
    function automatic int cnt_width(input int votes);
        return (votes < 1) ? 1 : $clog2(votes + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_VOTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SAMPLE,
        ST_RELAX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/puf_vote_engine_if.sv
// Challenge/response handshake bundle of the vote engine.
// master = the client issuing challenges, slave = the engine itself.
interface puf_vote_engine_if
    import puf_pkg::*;
#(
    parameter int N = DEF_N
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] challenge;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] response;
    logic [N-1:0] unstable;

    modport master (
        output req_valid,
        input  req_ready,
        output challenge,
        input  resp_valid,
        output resp_ready,
        input  response,
        input  unstable
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  challenge,
        output resp_valid,
        input  resp_ready,
        output response,
        output unstable
    );
endinterface

// File: rtl/puf_vote_engine_vote_counter.sv
// Per-bit vote accumulator: counts how many evaluations returned 1 and
// reports the majority value and whether the votes disagreed.
module vote_counter
    import puf_pkg::*;
#(
    parameter int VOTES = DEF_VOTES,
    parameter int W     = cnt_width(VOTES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic vote_bit,
    output logic maj,
    output logic unstable
);
    localparam logic [W-1:0] HALF = W'(VOTES / 2);
    localparam logic [W-1:0] ALL  = W'(VOTES);

    logic [W-1:0] count;

    // Count ones; cleared when a new challenge is accepted or on reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(vote_bit);
        end
    end

    assign maj      = (count > HALF);
    assign unstable = (count != '0) && (count != ALL);

endmodule

// File: rtl/puf_vote_engine.sv
// Arbiter-PUF majority-vote engine: applies a captured challenge, fires the
// delay-line launch edge VOTES times, accumulates the arbiter outputs per bit
// and returns the majority response together with a per-bit instability mask.
module puf_vote_engine
    import puf_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int VOTES  = DEF_VOTES,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               rst,
    puf_vote_engine_if.slave   bus,
    output logic [N-1:0]       puf_challenge,
    output logic               puf_signal,
    input  logic [N-1:0]       puf_response
);
    localparam int VW = cnt_width(VOTES);
    localparam int TW = cnt_width(SETTLE);
    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [VW-1:0] vidx;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic [N-1:0]  response_q;
    logic [N-1:0]  unstable_q;
    logic [N-1:0]  maj_vec;
    logic [N-1:0]  unst_vec;
    logic          cnt_clr;
    logic          cnt_en;

    assign cnt_clr = (state == ST_IDLE) && req_ready_q && bus.req_valid;
    assign cnt_en  = (state == ST_SAMPLE);

    for (genvar i = 0; i < N; i++) begin : g_bit
        vote_counter #(
            .VOTES (VOTES)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (cnt_clr),
            .en       (cnt_en),
            .vote_bit (puf_response[i]),
            .maj      (maj_vec[i]),
            .unstable (unst_vec[i])
        );
    end

    // Controller: sequences launch/sample/relax per vote, then holds the
    // registered result in DONE until the consumer takes it. The final
    // count lands at the end of the last SAMPLE, so the result is latched
    // on the first DONE cycle and resp_valid rises one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            timer         <= '0;
            vidx          <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            puf_signal    <= 1'b0;
            puf_challenge <= '0;
            response_q    <= '0;
            unstable_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        puf_challenge <= bus.challenge;
                        vidx          <= '0;
                        timer         <= SETTLE_LAST;
                        puf_signal    <= 1'b1;
                        req_ready_q   <= 1'b0;
                        state         <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (timer == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_SAMPLE: begin
                    puf_signal <= 1'b0;
                    timer      <= SETTLE_LAST;
                    state      <= ST_RELAX;
                end
                ST_RELAX: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (vidx < VOTE_LAST) begin
                        vidx       <= vidx + VW'(1);
                        timer      <= SETTLE_LAST;
                        puf_signal <= 1'b1;
                        state      <= ST_LAUNCH;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!resp_valid_q) begin
                        response_q   <= maj_vec;
                        unstable_q   <= unst_vec;
                        resp_valid_q <= 1'b1;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.response   = response_q;
    assign bus.unstable   = unstable_q;

endmodule

// File: tb/tb_puf_vote_engine.sv
// Self-checking bench for puf_vote_engine with N=8, VOTES=5, SETTLE=2.
module tb_puf_vote_engine;

    localparam int N      = 8;
    localparam int VOTES  = 5;
    localparam int SETTLE = 2;
    localparam int VOTE_CYC = 2 * SETTLE + 1;
    localparam int RUN_CYC  = VOTES * VOTE_CYC;

    typedef struct {
        string                 name;
        logic [7:0]            chal;
        logic [4:0][7:0]       seq;
        logic [7:0]            expResp;
        logic [7:0]            expUnst;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] puf_challenge;
    logic         puf_signal;
    logic [N-1:0] puf_response;

    int checkCount;
    int errorCount;

    vec_t vecs [5];

    puf_vote_engine_if #(.N(N)) bus ();

    puf_vote_engine #(
        .N      (N),
        .VOTES  (VOTES),
        .SETTLE (SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .puf_challenge (puf_challenge),
        .puf_signal    (puf_signal),
        .puf_response  (puf_response)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input string n, input logic [7:0] c,
                                   input logic [39:0] s, input logic [7:0] r,
                                   input logic [7:0] u);
        vec_t v;
        v.name    = n;
        v.chal    = c;
        v.seq     = s;
        v.expResp = r;
        v.expUnst = u;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one challenge and run it to the first cycle of resp_valid.
    // puf_response carries the intended vote only in the SAMPLE cycle and
    // its complement elsewhere, so sampling in the wrong cycle is visible.
    task automatic applyStimulus(input vec_t v);
        int         waitCnt;
        int         k;
        int         p;
        logic [RUN_CYC-1:0] wave;
        logic [RUN_CYC-1:0] expWave;
        logic       chalOk;
        logic       earlyOk;
        waitCnt = 0;
        while (bus.req_ready !== 1'b1 && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkOutput({v.name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        if (bus.req_ready !== 1'b1) return;
        bus.challenge = v.chal;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.challenge = ~v.chal;
        chalOk  = 1'b1;
        earlyOk = 1'b1;
        for (int c = 0; c < RUN_CYC; c++) begin
            k = c / VOTE_CYC;
            p = c % VOTE_CYC;
            puf_response = (p == SETTLE) ? v.seq[k] : ~v.seq[k];
            wave[c]    = puf_signal;
            expWave[c] = (p <= SETTLE);
            if (puf_challenge !== v.chal) chalOk = 1'b0;
            if (bus.resp_valid !== 1'b0) earlyOk = 1'b0;
            tick();
        end
        checkOutput({v.name, "_signal_wave"}, 32'(wave), 32'(expWave));
        checkOutput({v.name, "_chal_held"}, 32'(chalOk), 32'd1);
        checkOutput({v.name, "_no_early_valid"}, 32'(earlyOk), 32'd1);
        checkOutput({v.name, "_valid_at_25"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({v.name, "_signal_done"}, 32'(puf_signal), 32'd0);
        tick();
        checkOutput({v.name, "_valid_at_26"}, 32'(bus.resp_valid), 32'd1);
        checkOutput({v.name, "_response"}, 32'(bus.response), 32'(v.expResp));
        checkOutput({v.name, "_unstable"}, 32'(bus.unstable), 32'(v.expUnst));
        checkOutput({v.name, "_chal_done"}, 32'(puf_challenge), 32'(v.chal));
        checkOutput({v.name, "_ready_in_done"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic finishHandshake(input string name);
        tick();
        checkOutput({name, "_valid_after_hs"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({name, "_ready_after_hs"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic holdOk;
        logic noPulse;
        checkCount = 0;
        errorCount = 0;

        vecs[0] = mkVec("const_a5", 8'h3C, {5{8'hA5}}, 8'hA5, 8'h00);
        vecs[1] = mkVec("ff_mix",   8'h11, {8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF}, 8'hFF, 8'hFF);
        vecs[2] = mkVec("bit0_mix", 8'h22, {8'h00, 8'h01, 8'h00, 8'h01, 8'h00}, 8'h00, 8'h01);
        vecs[3] = mkVec("spread",   8'hC7, {8'h00, 8'hFF, 8'hAA, 8'hCC, 8'hF0}, 8'hE8, 8'hFF);
        vecs[4] = mkVec("all_zero", 8'hA0, {5{8'h00}}, 8'h00, 8'h00);

        bus.req_valid  = 1'b0;
        bus.challenge  = '0;
        bus.resp_ready = 1'b0;
        puf_response   = '0;
        rst            = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_puf_signal", 32'(puf_signal), 32'd0);
        checkOutput("rst_puf_challenge", 32'(puf_challenge), 32'd0);
        checkOutput("rst_response", 32'(bus.response), 32'd0);
        checkOutput("rst_unstable", 32'(bus.unstable), 32'd0);

        bus.resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            finishHandshake(vecs[i].name);
        end

        // Consumer stalls in DONE while a new request is already waiting.
        bus.resp_ready = 1'b0;
        applyStimulus(mkVec("stall", 8'h5A, {5{8'h33}}, 8'h33, 8'h00));
        bus.req_valid = 1'b1;
        bus.challenge = 8'h77;
        holdOk = 1'b1;
        repeat (10) begin
            tick();
            if (bus.resp_valid !== 1'b1 || bus.response !== 8'h33 ||
                bus.unstable !== 8'h00 || bus.req_ready !== 1'b0 ||
                puf_challenge !== 8'h5A) holdOk = 1'b0;
        end
        checkOutput("stall_outputs_held", 32'(holdOk), 32'd1);
        bus.resp_ready = 1'b1;
        tick();
        checkOutput("stall_valid_after_hs", 32'(bus.resp_valid), 32'd0);
        checkOutput("stall_ready_after_hs", 32'(bus.req_ready), 32'd1);
        checkOutput("stall_no_recapture", 32'(puf_challenge), 32'h5A);
        tick();
        checkOutput("stall_next_accepted", 32'(puf_challenge), 32'h77);
        checkOutput("stall_next_ready_low", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        puf_response  = 8'h55;

        // Abort that evaluation with reset during the third RELAX.
        repeat (2 * VOTE_CYC + SETTLE + 1) tick();
        checkOutput("abort_in_relax", 32'(puf_signal), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("abort_puf_signal", 32'(puf_signal), 32'd0);
        checkOutput("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("abort_puf_challenge", 32'(puf_challenge), 32'd0);
        checkOutput("abort_response", 32'(bus.response), 32'd0);
        noPulse = 1'b1;
        repeat (30) begin
            tick();
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) noPulse = 1'b0;
        end
        checkOutput("abort_no_resp_pulse", 32'(noPulse), 32'd1);

        applyStimulus(mkVec("after_rst", 8'h96, {5{8'h0F}}, 8'h0F, 8'h00));
        finishHandshake("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
